alu_mul_seq: RTL and testbench



---
 rtl/alu_mul_seq_if.sv | 44 ++++
 rtl/alu_mul_seq.sv | 183 ++++++++++++++++++
 tb/tb_alu_mul_seq.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/alu_mul_seq_if.sv
// -----------------------------------------------------------------------------
// alu_mul_seq_if
// Bundles the signals of the sequential multiplier:
//   requester side : start, a, b  ->  busy, done, result
//   ALU side       : alu_x, alu_y, alu_zx..alu_no  ->  alu_out, alu_zr, alu_ng
// Modports:
//   slave  - the multiplier controller (alu_mul_seq)
//   master - the environment (requester plus the shared Hack ALU)
// Parameter WIDTH : operand/result width, must equal the ALU width.
// -----------------------------------------------------------------------------
interface alu_mul_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  logic [WIDTH-1:0] alu_x;
  logic [WIDTH-1:0] alu_y;
  logic             alu_zx;
  logic             alu_nx;
  logic             alu_zy;
  logic             alu_ny;
  logic             alu_f;
  logic             alu_no;
  logic [WIDTH-1:0] alu_out;
  logic             alu_zr;
  logic             alu_ng;

  modport slave (
    input  start, a, b, alu_out, alu_zr, alu_ng,
    output busy, done, result,
    output alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no
  );

  modport master (
    output start, a, b, alu_out, alu_zr, alu_ng,
    input  busy, done, result,
    input  alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no
  );
endinterface

// File: rtl/alu_mul_seq.sv
// -----------------------------------------------------------------------------
// alu_mul_seq
// Multi-cycle 16-bit multiplier that borrows the shared combinational Hack ALU.
// MSB-first double-and-add: each multiplier bit costs one DBL cycle (prod+prod)
// plus one ADD cycle (prod+mcand) when the bit is set. Only the ALU op x+y is
// issued while busy; in IDLE/DONE the ALU is parked on the constant-0 op.
// Result is the low WIDTH bits of the product (same for signed/unsigned).
//
// Ports:
//   clk, rst_n  - rising-edge clock, asynchronous active-low reset
//   bus (slave) - start/a/b in, busy/done/result out, ALU operands/controls
//                 out, alu_out/alu_zr/alu_ng in
//
// Optional feature macro: MUL_ZERO_SHORTCUT_EN
//   defined   - a start with a==0 or b==0 goes straight to DONE, result 0
//   undefined - zero operands run the full sequence (still yielding 0)
// -----------------------------------------------------------------------------
module alu_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_mul_seq_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DBL,
    S_ADD,
    S_DONE
  } state_e;

  // ALU control word, ordered {zx, nx, zy, ny, f, no}
  localparam logic [5:0] ALU_ZERO = 6'b101010;
  localparam logic [5:0] ALU_ADD  = 6'b000010;

  state_e           state_q,  state_d;
  logic [WIDTH-1:0] prod_q,   prod_d;
  logic [WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;

  logic             last_bit;
  logic [5:0]       alu_ctrl;
  logic [WIDTH-1:0] alu_x_c;
  logic [WIDTH-1:0] alu_y_c;

  // The flag inputs are only meaningful for an alternative zero test.
  logic unused_alu_flags;
  assign unused_alu_flags = bus.alu_zr ^ bus.alu_ng;

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  // Next-state logic.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    state_d  = state_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          prod_d   = '0;
          mcand_d  = bus.a;
          mplier_d = bus.b;
          cnt_d    = '0;
          state_d  = S_DBL;
`ifdef MUL_ZERO_SHORTCUT_EN
          if ((bus.a == '0) || (bus.b == '0)) begin
            state_d = S_DONE;
          end
`endif
        end
      end

      S_DBL: begin
        prod_d = bus.alu_out;
        // A set bit stays in place until its ADD cycle consumes it.
        if (mplier_q[WIDTH-1]) begin
          state_d = S_ADD;
        end else if (last_bit) begin
          state_d = S_DONE;
        end else begin
          cnt_d    = cnt_q + CNT_W'(1);
          mplier_d = {mplier_q[WIDTH-2:0], 1'b0};
        end
      end

      S_ADD: begin
        prod_d = bus.alu_out;
        if (last_bit) begin
          state_d = S_DONE;
        end else begin
          cnt_d    = cnt_q + CNT_W'(1);
          mplier_d = {mplier_q[WIDTH-2:0], 1'b0};
          state_d  = S_DBL;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Registered handshake outputs follow the state being entered.
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
    result_d = (state_d == S_DONE) ? prod_d : result_q;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // ALU drive is a pure decode of the registered state and datapath.
  always_comb begin
    alu_ctrl = ALU_ZERO;
    alu_x_c  = '0;
    alu_y_c  = '0;
    unique case (state_q)
      S_DBL: begin
        alu_ctrl = ALU_ADD;
        alu_x_c  = prod_q;
        alu_y_c  = prod_q;
      end
      S_ADD: begin
        alu_ctrl = ALU_ADD;
        alu_x_c  = prod_q;
        alu_y_c  = mcand_q;
      end
      default: begin
        alu_ctrl = ALU_ZERO;
      end
    endcase
  end

  assign bus.alu_x  = alu_x_c;
  assign bus.alu_y  = alu_y_c;
  assign bus.alu_zx = alu_ctrl[5];
  assign bus.alu_nx = alu_ctrl[4];
  assign bus.alu_zy = alu_ctrl[3];
  assign bus.alu_ny = alu_ctrl[2];
  assign bus.alu_f  = alu_ctrl[1];
  assign bus.alu_no = alu_ctrl[0];

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_mul_seq
// Directed bench for alu_mul_seq. Includes a behavioural Hack ALU on the
// master side of the interface so the controller's ALU drive is exercised.
// Expected products and op-cycle counts (WIDTH + popcount(b)) are hand-computed.
// -----------------------------------------------------------------------------
module tb_alu_mul_seq;

  localparam int WIDTH  = 16;
  localparam int BUDGET = 100;

  logic clk;
  logic rst_n;

  int n_tests;
  int n_fail;

  alu_mul_seq_if #(.WIDTH(WIDTH)) bus ();

  alu_mul_seq #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Hack ALU behavioural model.
  logic [WIDTH-1:0] hx1, hx2, hy1, hy2, hf, ho;
  always_comb begin
    hx1 = bus.alu_zx ? '0 : bus.alu_x;
    hx2 = bus.alu_nx ? ~hx1 : hx1;
    hy1 = bus.alu_zy ? '0 : bus.alu_y;
    hy2 = bus.alu_ny ? ~hy1 : hy1;
    hf  = bus.alu_f ? (hx2 + hy2) : (hx2 & hy2);
    ho  = bus.alu_no ? ~hf : hf;
  end
  assign bus.alu_out = ho;
  assign bus.alu_zr  = (ho == '0);
  assign bus.alu_ng  = ho[WIDTH-1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] ctrl();
    return {bus.alu_zx, bus.alu_nx, bus.alu_zy, bus.alu_ny, bus.alu_f,
            bus.alu_no};
  endfunction

  // Present a request before the next edge; returns #1 after the start edge
  // (op cycle 1). With hold=1, start stays asserted.
  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input bit hold);
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) bus.start = 1'b0;
  endtask

  // Called at op cycle 1; counts cycles until done, then checks the result,
  // the one-cycle pulse and that the result holds across IDLE.
  task automatic wait_done(input string tag, input int exp_ops,
                           input logic [WIDTH-1:0] exp_res);
    int n;
    n = 1;
    if (exp_ops > 0) begin
      check({tag, "_ctrl_op"}, 32'(ctrl()), 32'(6'b000010));
    end
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    while (!bus.done && n < BUDGET) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_done_cycle"}, 32'(n), 32'(exp_ops + 1));
    check({tag, "_result"}, 32'(bus.result), 32'(exp_res));
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, {30'd0, bus.done, bus.busy}, 32'd0);
    check({tag, "_idle_ctrl"}, 32'(ctrl()), 32'(6'b101010));
    check({tag, "_hold"}, 32'(bus.result), 32'(exp_res));
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    rst_n     = 1'b0;
    #12;
    check("rst_busy",   32'(bus.busy),   32'd0);
    check("rst_done",   32'(bus.done),   32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_ctrl",   32'(ctrl()),     32'(6'b101010));
    check("rst_xy",     {bus.alu_x, bus.alu_y}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic: 3*5, b has two set bits -> 18 op cycles.
    start_op(16'd3, 16'd5, 1'b0);
    wait_done("basic", 18, 16'h000F);

    // Signed: -3*7 = -21, popcount(7)=3.
    start_op(16'hFFFD, 16'd7, 1'b0);
    wait_done("signed", 19, 16'hFFEB);

    // Max latency: 1*0xFFFF.
    start_op(16'd1, 16'hFFFF, 1'b0);
    wait_done("maxlat", 32, 16'hFFFF);

    // Wrap: 0x100*0x100 = 0x10000 -> 0.
    start_op(16'h0100, 16'h0100, 1'b0);
    wait_done("wrap", 17, 16'h0000);

    // Load a nonzero result, then reset mid-DBL.
    start_op(16'd3, 16'd3, 1'b0);
    wait_done("pre_rst", 18, 16'h0009);
    start_op(16'd3, 16'd5, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy",   32'(bus.busy),   32'd0);
    check("midrst_done",   32'(bus.done),   32'd0);
    check("midrst_result", 32'(bus.result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    start_op(16'd2, 16'd2, 1'b0);
    wait_done("after_rst", 17, 16'h0004);

    // start held through the whole op: no restart, second op on IDLE cycle.
    start_op(16'd9, 16'd9, 1'b1);
    wait_done("held", 18, 16'h0051);
    bus.a = 16'd2;
    bus.b = 16'd3;
    @(posedge clk);
    #1;
    check("held_restart_busy", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
    wait_done("held2", 18, 16'h0006);

    // Zero multiplier.
`ifdef MUL_ZERO_SHORTCUT_EN
    start_op(16'h1234, 16'd0, 1'b0);
    wait_done("zero", 0, 16'h0000);
`else
    start_op(16'h1234, 16'd0, 1'b0);
    wait_done("zero", 16, 16'h0000);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
